ps2_key_decoder: RTL

Receives the raw PS/2 keyboard serial stream (device-driven clock and data) and produces the 11-bit toggle-format `ps2_key` word consumed by core top levels' keyboard handlers. Input conditioning, frame reception, and scancode-set-2 prefix handling are all in the `clk_sys` domain. This lets a core take a directly attached PS/2 keyboard (e.g. on the user port) and feed the same keyboard logic used with the HPS-supplied word.

---
 rtl/ps2_key_decoder.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw lines, assembles 11-bit frames, and turns
// scancode-set-2 bytes into a toggle-format key word. Optional macro: PS2_PARITY_CHECK_EN.

module ps2_line_filter #(
  parameter int FILTER = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(FILTER + 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Level follows the synchronized line only after FILTER consecutive disagreeing samples.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module ps2_key_decoder #(
  parameter int FILTER         = 4,
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic        frame_err
);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  state_t        state;
  logic          clk_f, data_f, clk_prev;
  logic          bit_edge;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic [2:0]    skip_cnt;
  logic [WW-1:0] wd;
  logic          parity_bad;
`ifdef PS2_PARITY_CHECK_EN
  logic          parity;
`endif

  ps2_line_filter #(.FILTER(FILTER)) u_clk_filter (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .raw     (ps2_clk),
    .level   (clk_f)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_data_filter (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .raw     (ps2_data),
    .level   (data_f)
  );

  assign bit_edge = clk_prev & ~clk_f;

  // Odd parity: data plus parity bit must carry an odd number of ones.
  always_comb begin
    parity_bad = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_bad = ~(^{shift, parity});
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_prev   <= 1'b1;
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      skip_cnt   <= '0;
      wd         <= '0;
      ps2_key    <= '0;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity     <= 1'b0;
`endif
    end else begin
      clk_prev   <= clk_f;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_edge) begin
        wd <= '0;
        if (bit_cnt == 4'd0) begin
          if (data_f) frame_err <= 1'b1;
          else        bit_cnt   <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shift   <= {data_f, shift[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
          parity  <= data_f;
`endif
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if (!data_f || parity_bad) begin
            frame_err <= 1'b1;
          end else begin
            // Accepted byte: advance the scancode prefix machine.
            case (state)
              ST_IDLE: begin
                case (shift)
                  8'hE0: state <= ST_EXT;
                  8'hF0: state <= ST_BRK;
                  8'hE1: begin
                    state    <= ST_SKIP;
                    skip_cnt <= 3'd7;
                  end
                  8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state <= ST_IDLE;
                  default: begin
                    ps2_key    <= {~ps2_key[10], 1'b1, 1'b0, shift};
                    key_strobe <= 1'b1;
                  end
                endcase
              end
              ST_EXT: begin
                if (shift == 8'hF0) begin
                  state <= ST_EXT_BRK;
                end else if (shift != 8'hE0) begin
                  ps2_key    <= {~ps2_key[10], 1'b1, 1'b1, shift};
                  key_strobe <= 1'b1;
                  state      <= ST_IDLE;
                end
              end
              ST_BRK: begin
                ps2_key    <= {~ps2_key[10], 1'b0, 1'b0, shift};
                key_strobe <= 1'b1;
                state      <= ST_IDLE;
              end
              ST_EXT_BRK: begin
                ps2_key    <= {~ps2_key[10], 1'b0, 1'b1, shift};
                key_strobe <= 1'b1;
                state      <= ST_IDLE;
              end
              ST_SKIP: begin
                skip_cnt <= skip_cnt - 3'd1;
                if (skip_cnt == 3'd1) state <= ST_IDLE;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      end else begin
        // Watchdog saturates; a stalled partial frame is dropped once.
        if (wd != WW'(TIMEOUT_CYCLES)) wd <= wd + WW'(1);
        if (bit_cnt != 4'd0 && wd == WW'(TIMEOUT_CYCLES)) begin
          bit_cnt   <= 4'd0;
          frame_err <= 1'b1;
        end
      end
    end
  end
endmodule
